// File: rtl/rv_pkg.sv
// Shared RV32 fetch definitions: opcodes, immediate extraction and the
// 2-bit branch-history counter type with its saturating update.
package rv_pkg;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  typedef logic [1:0] bht_ctr_t;

  localparam bht_ctr_t BHT_INIT = 2'b01;

  function automatic logic [31:0] imm_b(input logic [31:0] instr);
    return {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  endfunction

  function automatic logic [31:0] imm_j(input logic [31:0] instr);
    return {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  endfunction

  function automatic bht_ctr_t bht_sat_update(input bht_ctr_t ctr, input logic taken);
    if (taken) begin
      return (ctr == 2'b11) ? ctr : ctr + 2'd1;
    end
    return (ctr == 2'b00) ? ctr : ctr - 2'd1;
  endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// Fetch-stage bundle: instruction memory, hazard stall, EX resolution feedback
// and the IF/ID outputs. master = fetch unit, slave = its environment.
interface if_fetch_unit_if;

  logic        pc_write_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic [31:0] pc_plus_4_o;
  logic        prediction_o;
  logic [31:0] pred_target_o;
  logic        res_valid;
  logic        res_is_cond;
  logic [31:0] res_pc;
  logic        res_taken;
  logic [31:0] res_target;
  logic        res_pred;
  logic [31:0] res_pred_target;
  logic        flush_o;

  modport master (
    input  pc_write_en, imem_rdata,
    input  res_valid, res_is_cond, res_pc, res_taken, res_target, res_pred, res_pred_target,
    output imem_addr, instr_o, pc_o, pc_plus_4_o, prediction_o, pred_target_o, flush_o
  );

  modport slave (
    output pc_write_en, imem_rdata,
    output res_valid, res_is_cond, res_pc, res_taken, res_target, res_pred, res_pred_target,
    input  imem_addr, instr_o, pc_o, pc_plus_4_o, prediction_o, pred_target_o, flush_o
  );

endinterface

// File: rtl/if_fetch_unit_bht.sv
// 2-bit saturating branch history table: combinational read, clocked update.
// The read returns the pre-update value when read and update hit one entry.
module bht_2bit
  import rv_pkg::*;
#(
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IDX_W-1:0] rd_idx,
  output bht_ctr_t         rd_ctr,
  input  logic             upd_en,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken
);

  localparam int ENTRIES = 2 ** IDX_W;

  logic [2*ENTRIES-1:0] ctr_flat;

  // Registers rather than RAM: every entry must clear on the async reset.
  genvar gi;
  generate
    for (gi = 0; gi < ENTRIES; gi++) begin : g_ent
      bht_ctr_t ctr_reg;

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          ctr_reg <= BHT_INIT;
        end else if (upd_en && (upd_idx == IDX_W'(gi))) begin
          ctr_reg <= bht_sat_update(ctr_reg, upd_taken);
        end
      end

      assign ctr_flat[2*gi +: 2] = ctr_reg;
    end
  endgenerate

  assign rd_ctr = ctr_flat[2*rd_idx +: 2];

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC register, static JAL / BHT-based branch
// prediction, and redirect + flush on EX-stage mispredicts.
module if_fetch_unit
  import rv_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BHT_IDX_W = 4
) (
  input  logic          clk,
  input  logic          reset,
  if_fetch_unit_if.master fif
);

  logic [31:0] pc_reg;
  logic [31:0] pc_next;
  logic [31:0] pc_plus_4;
  logic [31:0] imm;
  logic [31:0] pred_target;
  logic [6:0]  opcode;
  logic        is_branch;
  logic        is_jal;
  logic        prediction;
  logic        mispred;
  bht_ctr_t    rd_ctr;

  assign opcode    = fif.imem_rdata[6:0];
  assign pc_plus_4 = pc_reg + 32'd4;

  always_comb begin
    imm       = '0;
    is_branch = 1'b0;
    is_jal    = 1'b0;
    case (opcode)
      OPC_BRANCH: begin
        imm       = imm_b(fif.imem_rdata);
        is_branch = 1'b1;
      end
      OPC_JAL: begin
        imm    = imm_j(fif.imem_rdata);
        is_jal = 1'b1;
      end
      default: ;
    endcase
  end

  assign prediction  = is_jal | (is_branch & rd_ctr[1]);
  assign pred_target = (is_branch | is_jal) ? pc_reg + imm : pc_plus_4;

  // A correct direction with a wrong target still counts as a mispredict.
  assign mispred = fif.res_valid &
                   ((fif.res_taken != fif.res_pred) |
                    (fif.res_taken & (fif.res_target != fif.res_pred_target)));

  // Redirect beats a stall so a squashed wrong path can never stay frozen.
  always_comb begin
    pc_next = pc_plus_4;
    if (mispred) begin
      pc_next = fif.res_taken ? fif.res_target : fif.res_pc + 32'd4;
    end else if (!fif.pc_write_en) begin
      pc_next = pc_reg;
    end else if (prediction) begin
      pc_next = pred_target;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_reg <= RESET_PC;
    end else begin
      pc_reg <= pc_next;
    end
  end

  bht_2bit #(
    .IDX_W (BHT_IDX_W)
  ) u_bht (
    .clk       (clk),
    .reset     (reset),
    .rd_idx    (pc_reg[BHT_IDX_W+1:2]),
    .rd_ctr    (rd_ctr),
    .upd_en    (fif.res_valid & fif.res_is_cond),
    .upd_idx   (fif.res_pc[BHT_IDX_W+1:2]),
    .upd_taken (fif.res_taken)
  );

  assign fif.imem_addr     = pc_reg;
  assign fif.instr_o       = fif.imem_rdata;
  assign fif.pc_o          = pc_reg;
  assign fif.pc_plus_4_o   = pc_plus_4;
  assign fif.prediction_o  = prediction;
  assign fif.pred_target_o = pred_target;
  assign fif.flush_o       = mispred & reset;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: a reference model pushes the expected
// fetch bundle per cycle into a scoreboard that is popped against the DUT.
module tb_if_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] instr;
    logic [31:0] tgt;
    logic        pred;
    logic        flush;
  } exp_t;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;
  int   n_txn;

  logic [31:0] model_pc;
  logic [1:0]  model_bht [16];
  exp_t        sb_q [$];

  if_fetch_unit_if fif ();

  if_fetch_unit #(
    .RESET_PC  (32'h0000_0000),
    .BHT_IDX_W (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .fif   (fif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] enc_b(input logic [31:0] imm);
    return {imm[12], imm[10:5], 5'd0, 5'd0, 3'd0, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_j(input logic [31:0] imm);
    return {imm[20], imm[10:1], imm[11], imm[19:12], 5'd0, 7'b1101111};
  endfunction

  task automatic model_reset();
    model_pc = 32'h0;
    for (int i = 0; i < 16; i++) model_bht[i] = 2'b01;
  endtask

  task automatic drive_res(input logic rv, input logic rc, input logic [31:0] rpc,
                           input logic rt, input logic [31:0] rtgt,
                           input logic rp, input logic [31:0] rptgt);
    fif.res_valid       = rv;
    fif.res_is_cond     = rc;
    fif.res_pc          = rpc;
    fif.res_taken       = rt;
    fif.res_target      = rtgt;
    fif.res_pred        = rp;
    fif.res_pred_target = rptgt;
  endtask

  // One fetch cycle: drive, predict, compare after settling, advance model and clock.
  task automatic step(input logic [31:0] instr, input logic [31:0] imm, input logic we,
                      input logic rv, input logic rc, input logic [31:0] rpc,
                      input logic rt, input logic [31:0] rtgt,
                      input logic rp, input logic [31:0] rptgt);
    exp_t e;
    exp_t got;
    logic is_b;
    logic is_j;
    logic [1:0] ctr;
    fif.imem_rdata  = instr;
    fif.pc_write_en = we;
    drive_res(rv, rc, rpc, rt, rtgt, rp, rptgt);
    is_b    = (instr[6:0] == 7'b1100011);
    is_j    = (instr[6:0] == 7'b1101111);
    ctr     = model_bht[model_pc[5:2]];
    e.pc    = model_pc;
    e.pc4   = model_pc + 32'd4;
    e.instr = instr;
    e.pred  = is_j | (is_b & ctr[1]);
    e.tgt   = (is_b | is_j) ? model_pc + imm : model_pc + 32'd4;
    e.flush = rv & ((rt != rp) | (rt & (rtgt != rptgt)));
    sb_q.push_back(e);
    #1;
    got = sb_q.pop_front();
    chk("pc_o", fif.pc_o, got.pc);
    chk("imem_addr", fif.imem_addr, got.pc);
    chk("pc_plus_4_o", fif.pc_plus_4_o, got.pc4);
    chk("instr_o", fif.instr_o, got.instr);
    chk("prediction_o", {31'd0, fif.prediction_o}, {31'd0, got.pred});
    chk("pred_target_o", fif.pred_target_o, got.tgt);
    chk("flush_o", {31'd0, fif.flush_o}, {31'd0, got.flush});
    $display("txn %0d pc=%h instr=%h we=%0b pred=%0b tgt=%h flush=%0b",
             n_txn, fif.pc_o, instr, we, fif.prediction_o, fif.pred_target_o, fif.flush_o);
    n_txn++;
    if (got.flush) model_pc = rt ? rtgt : rpc + 32'd4;
    else if (!we) model_pc = model_pc;
    else if (got.pred) model_pc = got.tgt;
    else model_pc = model_pc + 32'd4;
    if (rv && rc) begin
      if (rt) model_bht[rpc[5:2]] = (ctr_at(rpc) == 2'b11) ? 2'b11 : ctr_at(rpc) + 2'd1;
      else    model_bht[rpc[5:2]] = (ctr_at(rpc) == 2'b00) ? 2'b00 : ctr_at(rpc) - 2'd1;
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] ctr_at(input logic [31:0] a);
    return model_bht[a[5:2]];
  endfunction

  task automatic nop(input logic we);
    step(NOP, 32'h0, we, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  // Force a redirect through a taken-but-predicted-not-taken resolution.
  task automatic go(input logic [31:0] tgt);
    step(NOP, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, tgt, 1'b0, 32'h0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    n_txn    = 0;
    reset    = 1'b0;
    fif.imem_rdata  = NOP;
    fif.pc_write_en = 1'b1;
    drive_res(1'b1, 1'b0, 32'h0, 1'b1, 32'h200, 1'b0, 32'h0);
    model_reset();
    #12;
    chk("rst_pc", fif.pc_o, 32'h0);
    chk("rst_pc4", fif.pc_plus_4_o, 32'h4);
    chk("rst_flush", {31'd0, fif.flush_o}, 32'h0);
    drive_res(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    reset = 1'b1;

    for (int i = 0; i < 4; i++) begin
      chk("pc_seq", fif.pc_o, 32'(i * 4));
      nop(1'b1);
    end

    step(enc_j(32'h20), 32'h20, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("jal_nobubble", fif.pc_o, 32'h30);

    step(NOP, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h100, 1'b0, 32'h0);
    chk("redirect_beats_stall", fif.pc_o, 32'h100);

    go(32'h20);
    for (int i = 0; i < 3; i++) nop(1'b0);
    chk("stall_hold", fif.pc_o, 32'h20);
    nop(1'b1);
    chk("stall_release", fif.pc_o, 32'h24);

    go(32'h40);
    for (int i = 0; i < 3; i++)
      step(enc_b(-32'sd16), -32'sd16, 1'b0, 1'b1, 1'b1, 32'h40, 1'b1, 32'h30, 1'b1, 32'h30);
    chk("bht_sat_pred", {31'd0, fif.prediction_o}, 32'h1);
    step(enc_b(-32'sd16), -32'sd16, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("b_taken_pc", fif.pc_o, 32'h30);

    go(32'h40);
    for (int i = 0; i < 3; i++)
      step(enc_b(-32'sd16), -32'sd16, 1'b0, 1'b1, 1'b1, 32'h40, 1'b0, 32'h44, 1'b0, 32'h44);
    step(enc_b(-32'sd16), -32'sd16, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("b_nottaken_pc", fif.pc_o, 32'h44);

    go(32'hFFFF_FFF8);
    step(enc_j(32'h10), 32'h10, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("jal_wrap", fif.pc_o, 32'h8);

    go(32'h102);
    chk("misaligned", fif.pc_o, 32'h102);
    nop(1'b1);
    step(NOP, 32'h0, 1'b1, 1'b1, 1'b1, 32'h500, 1'b0, 32'h0, 1'b1, 32'h600);
    chk("nottaken_redirect", fif.pc_o, 32'h504);
    step(NOP, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h80, 1'b1, 32'h90);
    chk("target_mispred", fif.pc_o, 32'h80);

    drive_res(1'b1, 1'b0, 32'h0, 1'b1, 32'h300, 1'b0, 32'h0);
    fif.pc_write_en = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    chk("async_rst_pc", fif.pc_o, 32'h0);
    chk("async_rst_pc4", fif.pc_plus_4_o, 32'h4);
    chk("async_rst_flush", {31'd0, fif.flush_o}, 32'h0);
    model_reset();
    #2;
    reset = 1'b1;
    drive_res(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);

    for (int i = 0; i < 16; i++)
      step(enc_b(32'h8), 32'h8, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    step(enc_b(32'h8), 32'h8, 1'b0, 1'b1, 1'b1, 32'h40, 1'b1, 32'h48, 1'b1, 32'h48);
    chk("bht_rst_weak", {31'd0, fif.prediction_o}, 32'h1);
    step(enc_b(32'h8), 32'h8, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch stage that produces the per-cycle fetch bundle consumed by the IF/ID pipeline register.
- Bundle contents: instruction word, PC+4, branch prediction bit, predicted target.
- Owns the PC register and a 2-bit saturating branch history table (BHT).
- Honours the hazard unit's write-enable and redirects on EX-stage branch resolution, raising the flush that squashes IF/ID.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- BHT_IDX_W, 4, BHT index width; table has 2**BHT_IDX_W entries indexed by pc[BHT_IDX_W+1:2].

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- pc_write_en  input  1  from stalling unit; 1 = PC may advance, 0 = hold PC
- imem_addr  output  32  instruction memory address (= PC)
- imem_rdata  input  32  instruction word, combinational same-cycle read
- instr_o  output  32  instruction to IF/ID (= imem_rdata)
- pc_o  output  32  current PC
- pc_plus_4_o  output  32  PC+4
- prediction_o  output  1  1 = predicted taken
- pred_target_o  output  32  PC + decoded immediate (B or J type), else PC+4
- res_valid  input  1  EX resolving a control instruction this cycle
- res_is_cond  input  1  resolved instruction is a conditional branch (trains BHT)
- res_pc  input  32  PC of resolved instruction
- res_taken  input  1  actual outcome
- res_target  input  32  actual target
- res_pred  input  1  prediction carried down the pipe
- res_pred_target  input  32  predicted target carried down the pipe
- flush_o  output  1  squash IF/ID (and ID/EX) this cycle

Behaviour:
- Reset (async, active-low):
  - PC <= RESET_PC.
  - All BHT entries <= 2'b01 (weakly not-taken).
  - While in reset: pc_o = RESET_PC, pc_plus_4_o = RESET_PC+4, flush_o = 0.
  - instr_o, prediction_o and pred_target_o follow imem_rdata.
- Decode, combinational on instr_o:
  - opcode 1100011: B-immediate {imm[12|10:5|4:1|11],0}, sign-extended.
  - opcode 1101111: J-immediate {imm[20|10:1|11|19:12],0}, sign-extended.
  - Any other opcode: immediate unused.
- Prediction, combinational:
  - B-type: prediction_o = BHT[idx][1].
  - JAL: prediction_o = 1.
  - All other opcodes (including JALR): prediction_o = 0.
  - pred_target_o = PC + imm for B and JAL; otherwise PC+4. Arithmetic is 32-bit modulo 2^32 (wrap, no error).
- Mispredict:
  - mispred = res_valid & ((res_taken != res_pred) | (res_taken & res_target != res_pred_target)).
  - flush_o = mispred, combinational, asserted in the same cycle.
- Next PC, priority high to low:
  1. mispred: res_taken ? res_target : res_pc+4. Overrides pc_write_en = 0.
  2. pc_write_en = 0: hold.
  3. prediction_o = 1: pred_target_o.
  4. Otherwise: PC+4.
- BHT update at posedge when res_valid & res_is_cond:
  - Taken increments the entry, saturating at 11.
  - Not-taken decrements the entry, saturating at 00.
  - Index is res_pc[BHT_IDX_W+1:2].
  - Update occurs regardless of stall.
- Read/write same entry in the same cycle: lookup returns the pre-update value; the new value is visible next cycle.
- Latency:
  - Redirect takes effect one cycle after the mispredict cycle.
  - Predicted-taken fetch proceeds with zero bubbles.
- Reset asserted mid-stall or mid-redirect: reset wins immediately.
- PC low bits [1:0] are never forced; misaligned targets pass through unchanged (trap handling is out of scope).

Decomposition:
- Shared package rv_pkg holds:
  - Opcode constants OPC_BRANCH = 7'b1100011, OPC_JAL = 7'b1101111, OPC_JALR = 7'b1100111.
  - Immediate-extraction functions imm_b() and imm_j().
  - Typedef bht_ctr_t (2-bit counter).
- One sub-module, bht_2bit:
  - Parameterised table with a read port and a saturating update port.
  - Async active-low reset to 01.

Test Plan:
- Reset then free-run, pc_write_en = 1, non-branch instrs:
  - pc_o = 0, 4, 8, 12 on successive cycles.
  - prediction_o = 0, flush_o = 0.
- JAL at PC 0x10 with imm +0x20:
  - prediction_o = 1, pred_target_o = 0x30.
  - Next pc_o = 0x30 with no bubble.
- Train BHT for B-type at PC 0x40 (idx 0) over three cycles with res_taken = 1:
  - Counter goes 01 -> 10 -> 11 -> 11 (saturates).
  - Then prediction_o = 1 on fetch at 0x40; after three not-taken updates the counter reaches 00 and prediction_o = 0.
- Mispredict with pc_write_en = 0 held:
  - Stimulus: res_valid = 1, res_pred = 0, res_taken = 1, res_target = 0x100.
  - flush_o = 1 that cycle; next pc_o = 0x100 (redirect beats stall).
- Stall: pc_write_en = 0 for 3 cycles at PC 0x20:
  - pc_o stays 0x20, then advances to 0x24.
- Async reset at PC 0x80 mid-cycle (negedge reset between clocks):
  - pc_o = 0 immediately.
  - All BHT entries read 01 afterward.
